seg_scan_ctrl: RTL

Parametrised multiplexed 7-segment scan controller. It drives NUM_DIG common-select lines and one shared 8-bit segment bus from packed hex nibbles. Compared with the fixed 6-digit scanner, it adds:
- a programmable dwell per digit and anti-ghost blanking;
- 16-level brightness PWM, per-digit enable and decimal point;
- leading-zero suppression and tear-free frame snapshotting;
- a parametrised physical digit map and output polarity.

It sits between the display-data registers and the board pins.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg_glyph_dec.sv | 11 +
 rtl/seg_scan_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: glyph table, scan phase encodings and
// elaboration-time parameter guards for display blocks.
`ifndef SEG_PKG_SV
`define SEG_PKG_SV

// Emits a named generate block that aborts elaboration when cond is false.
`define SEG_PARAM_CHK(lbl, cond) \
   if (!(cond)) begin : lbl \
      $error("illegal parameter"); \
   end

package seg_pkg;

   localparam int         SEG_DP_BIT  = 7;
   localparam logic [7:0] SEG_DP_ONLY = 8'(1) << SEG_DP_BIT;

   typedef enum logic [1:0] {
      PH_BLANK = 2'd0,
      PH_ON    = 2'd1,
      PH_OFF   = 2'd2
   } phase_e;

   // Active-high {g,f,e,d,c,b,a}, indexed by nibble value (entry 0 is rightmost).
   localparam logic [15:0][6:0] GLYPH_TBL = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

`endif

// File: rtl/seg_glyph_dec.sv
// Combinational nibble to active-high 7-segment glyph {g,f,e,d,c,b,a}.
module seg_glyph_dec
   import seg_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] glyph_o
);

   assign glyph_o = GLYPH_TBL[nib_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner: per-digit dwell with anti-ghost blanking,
// 16-level PWM, leading-zero suppression and per-frame input snapshot.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int                   NUM_DIG     = 6,
   parameter int                   DWELL_CYC   = 100,
   parameter int                   BLANK_CYC   = 1,
   parameter logic [3*NUM_DIG-1:0] DIG_MAP     = {3'd2, 3'd3, 3'd0, 3'd1, 3'd4, 3'd5},
   parameter bit                   DIG_ACT_LOW = 1'b0,
   parameter bit                   SEG_ACT_LOW = 1'b0
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [4*NUM_DIG-1:0]   i_data,
   input  logic [NUM_DIG-1:0]     i_dp,
   input  logic [NUM_DIG-1:0]     i_dig_en,
   input  logic                   i_lz_sup,
   input  logic [3:0]             i_bright,
   output logic [7:0]             SEG,
   output logic [NUM_DIG-1:0]     DIG,
   output logic                   o_frame_start
);

   localparam int CW = $clog2(DWELL_CYC);
   localparam int SW = $clog2(NUM_DIG);
   localparam logic [NUM_DIG-1:0] DIG_ONE = {{(NUM_DIG-1){1'b0}}, 1'b1};

   `SEG_PARAM_CHK(g_bad_num_dig, NUM_DIG >= 2 && NUM_DIG <= 8)
   `SEG_PARAM_CHK(g_bad_dwell, DWELL_CYC >= 2)
   `SEG_PARAM_CHK(g_bad_blank, BLANK_CYC >= 1 && BLANK_CYC <= DWELL_CYC - 1)

   logic [CW-1:0]          cnt_q, cnt_d;
   logic [SW-1:0]          slot_q, slot_d;
   phase_e                 phase_q, ph_d;
   logic [4*NUM_DIG-1:0]   data_q;
   logic [NUM_DIG-1:0]     dp_q, en_q;
   logic                   lz_q;
   logic [3:0]             bright_q, br_nxt;
   logic [NUM_DIG-1:0]     dig_q;
   logic [7:0]             seg_q;
   logic                   fs_q;
   logic                   snap;

   assign snap   = (cnt_q == '0) && (slot_q == '0);
   // Phase of the next count must see the brightness that loads on this edge.
   assign br_nxt = snap ? i_bright : bright_q;

   function automatic logic on_hit(input logic [CW-1:0] c, input logic [3:0] br);
      return (int'(c) - BLANK_CYC) * 16 < (DWELL_CYC - BLANK_CYC) * (int'(br) + 1);
   endfunction

   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      slot_d = slot_q;
      if (cnt_q == CW'(DWELL_CYC - 1)) begin
         cnt_d  = '0;
         slot_d = (slot_q == SW'(NUM_DIG - 1)) ? '0 : slot_q + 1'b1;
      end
   end

   // phase_q always describes cnt_q; ph_d describes cnt_d.
   always_comb begin
      ph_d = phase_q;
      case (phase_q)
         PH_BLANK: if (int'(cnt_d) >= BLANK_CYC) ph_d = on_hit(cnt_d, br_nxt) ? PH_ON : PH_OFF;
         PH_ON: begin
            if (cnt_d == '0)                 ph_d = PH_BLANK;
            else if (!on_hit(cnt_d, br_nxt)) ph_d = PH_OFF;
         end
         PH_OFF:   if (cnt_d == '0) ph_d = PH_BLANK;
         default:  ph_d = PH_BLANK;
      endcase
   end

   logic [NUM_DIG-1:0][6:0]         glyph_v;
   logic [NUM_DIG-1:0][7:0]         seg_v;
   logic [NUM_DIG-1:0][NUM_DIG-1:0] dig_v;
   logic [NUM_DIG-1:0]              supp, lit;

   for (genvar k = 0; k < NUM_DIG; k++) begin : g_lane
      `SEG_PARAM_CHK(g_bad_map, int'(DIG_MAP[3*k +: 3]) < NUM_DIG)

      seg_glyph_dec u_dec (
         .nib_i   (data_q[4*k +: 4]),
         .glyph_o (glyph_v[k])
      );

      if (k == 0) begin : g_lsd
         assign supp[k] = 1'b0;
      end else begin : g_upper
         assign supp[k] = lz_q && (data_q[4*NUM_DIG-1:4*k] == '0);
      end

      // A suppressed digit still lights when it carries the decimal point.
      assign lit[k]   = en_q[k] && (!supp[k] || dp_q[k]);
      assign seg_v[k] = !lit[k] ? 8'h00 : supp[k] ? SEG_DP_ONLY : {dp_q[k], glyph_v[k]};
      assign dig_v[k] = lit[k] ? (DIG_ONE << DIG_MAP[3*k +: 3]) : '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q    <= '0;
         slot_q   <= '0;
         phase_q  <= PH_BLANK;
         data_q   <= '0;
         dp_q     <= '0;
         en_q     <= '0;
         lz_q     <= 1'b0;
         bright_q <= '0;
         dig_q    <= {NUM_DIG{DIG_ACT_LOW}};
         seg_q    <= {8{SEG_ACT_LOW}};
         fs_q     <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         slot_q  <= slot_d;
         phase_q <= ph_d;
         if (snap) begin
            data_q   <= i_data;
            dp_q     <= i_dp;
            en_q     <= i_dig_en;
            lz_q     <= i_lz_sup;
            bright_q <= i_bright;
         end
         fs_q  <= snap;
         dig_q <= ((phase_q == PH_ON) ? dig_v[slot_q] : '0) ^ {NUM_DIG{DIG_ACT_LOW}};
         seg_q <= ((phase_q == PH_ON) ? seg_v[slot_q] : 8'h00) ^ {8{SEG_ACT_LOW}};
      end
   end

   assign DIG           = dig_q;
   assign SEG           = seg_q;
   assign o_frame_start = fs_q;

endmodule
